fire_expand_seq: RTL and testbench
==================================

Name: fire_expand_seq

Overview:
- Layer sequencer for one fire expand1x1 MAC-array layer. One instance per layer.
- Generates input-feature-map read addresses and the layer enable that drives the MAC array.
- Waits for the array's sample strobe, then serially drains the DSP_NO parallel results into the output feature-map RAM, one output pixel at a time, until all WOUT*WOUT pixels are done.
- Sits between the input RAM, the MAC-array layer block and the output RAM.

Parameters:
- WOUT, 8: output width/height; pixels per layer = WOUT*WOUT.
- CHIN, 112: input channels accumulated per output pixel.
- DSP_NO, 256: parallel output channels (MACs) to drain per pixel.
- SAMPLE_LAT, 4: maximum expected cycles from end of enable run to sample_i. Used only by the optional feature.

Localparams:
- IFM_AW = $clog2(WOUT*WOUT*CHIN)
- OFM_AW = $clog2(WOUT*WOUT*DSP_NO)
- SEL_W = $clog2(DSP_NO)

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle start pulse; ignored unless idle.
- layer_en_o  out  1  enable to the MAC-array layer.
- ifm_rd_o  out  1  input RAM read strobe.
- ifm_addr_o  out  IFM_AW  input RAM address.
- sample_i  in  1  MAC-array result-valid strobe.
- wr_ready_i  in  1  output RAM / downstream ready (ram_feedback).
- wr_en_o  out  1  output RAM write strobe.
- wr_sel_o  out  SEL_W  index of the ofm word being written.
- wr_addr_o  out  OFM_AW  output RAM address.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse at layer completion.

Behaviour:
- Reset: FSM=IDLE; all counters 0; every output 0. Reset mid-operation aborts immediately, with no done pulse.
- States: IDLE, RUN, WAIT, DRAIN, DONE.
- IDLE:
  - start_i=1 -> RUN next cycle; busy_o=1.
  - pix_cnt=0, ch_cnt=0.
- RUN:
  - Lasts exactly CHIN+1 cycles.
  - layer_en_o=1 every RUN cycle.
  - For ch_cnt=0..CHIN-1: ifm_rd_o=1, ifm_addr_o = pix_cnt*CHIN + ch_cnt (registered output).
  - Cycle CHIN is the array's clear slot: ifm_rd_o=0, address held.
  - After the clear slot, ch_cnt resets to 0 and the FSM goes to WAIT.
- WAIT:
  - layer_en_o=0.
  - On sample_i=1 -> DRAIN with sel_cnt=0.
  - sample_i outside WAIT is ignored.
- DRAIN:
  - While wr_ready_i=1: wr_en_o=1, wr_sel_o=sel_cnt, wr_addr_o = pix_cnt*DSP_NO + sel_cnt; sel_cnt increments.
  - wr_ready_i=0 stalls: wr_en_o=0, sel_cnt and address held.
  - When the write with sel_cnt=DSP_NO-1 is accepted:
    - if pix_cnt=WOUT*WOUT-1 -> DONE;
    - else pix_cnt+1 -> RUN.
- DONE: done_o=1 for one cycle, busy_o falls, -> IDLE.
- start_i while busy is dropped and not queued. start_i in the same cycle as DONE is ignored.
- Counters never wrap within a layer. pix_cnt saturates at terminal, and addresses never exceed WOUT*WOUT*CHIN-1 or WOUT*WOUT*DSP_NO-1.
- Address arithmetic is unsigned. Products are computed with incremental adders, not multipliers (base += CHIN / DSP_NO per pixel).
- Latency:
  - start_i to first layer_en_o: 1 cycle.
  - Per pixel, with no stall: (CHIN+1) + wait + DSP_NO cycles.

Optional Feature:
- Macro: FIRE_SEQ_SAMPLE_TIMEOUT_EN.
- Defined:
  - Adds output port err_o (1 bit).
  - A WAIT-state counter runs; if sample_i is not seen within SAMPLE_LAT+8 cycles, the FSM goes to IDLE (no done pulse), busy_o=0, and err_o=1.
  - err_o is sticky; it clears on the next accepted start_i or on rst.
- Undefined: WAIT waits indefinitely for sample_i; no err_o port and no counter logic.

Test Plan (WOUT=2, CHIN=4, DSP_NO=4 unless noted):
- Reset held, then released:
  - all outputs 0;
  - start_i pulse -> layer_en_o high 5 cycles;
  - ifm_addr_o 0,1,2,3 with ifm_rd_o=1, then 1 clear cycle with ifm_rd_o=0.
- sample_i 3 cycles after RUN, wr_ready_i=1:
  - wr_en_o 4 cycles, wr_sel_o 0..3, wr_addr_o 0..3;
  - second RUN reads ifm_addr_o 4..7.
- Full layer, ready held high:
  - 4 pixels, 16 writes with wr_addr_o 0..15;
  - done_o single pulse after the write to address 15;
  - busy_o drops the same cycle.
- wr_ready_i low for 3 cycles at sel=2 of pixel 1:
  - wr_en_o=0, wr_addr_o held at 6 during the stall;
  - resumes at 6,7; no duplicate or skipped address.
- start_i mid-layer: ignored, with an identical write sequence. rst asserted during DRAIN: outputs 0 asynchronously, no done_o; a subsequent start_i restarts from address 0.
- With FIRE_SEQ_SAMPLE_TIMEOUT_EN, SAMPLE_LAT=4, sample_i withheld:
  - err_o=1 at 12 WAIT cycles, FSM idle, busy_o=0;
  - next start_i clears err_o.

Source files
------------

// File: rtl/fire_expand_seq.sv
// fire_expand_seq: expand1x1 layer sequencer (ifm reads, MAC enable, ofm drain).
// Optional WAIT timeout with sticky err_o: define FIRE_SEQ_SAMPLE_TIMEOUT_EN.
module fire_expand_seq #(
  parameter int WOUT       = 8,
  parameter int CHIN       = 112,
  parameter int DSP_NO     = 256,
  parameter int SAMPLE_LAT = 4,
  localparam int IFM_AW    = $clog2(WOUT*WOUT*CHIN),
  localparam int OFM_AW    = $clog2(WOUT*WOUT*DSP_NO),
  localparam int SEL_W     = $clog2(DSP_NO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              layer_en_o,
  output logic              ifm_rd_o,
  output logic [IFM_AW-1:0] ifm_addr_o,
  input  logic              sample_i,
  input  logic              wr_ready_i,
  output logic              wr_en_o,
  output logic [SEL_W-1:0]  wr_sel_o,
  output logic [OFM_AW-1:0] wr_addr_o,
`ifdef FIRE_SEQ_SAMPLE_TIMEOUT_EN
  output logic              err_o,
`endif
  output logic              busy_o,
  output logic              done_o
);

  localparam int CH_W  = $clog2(CHIN+1);
  localparam int PIX_W = $clog2(WOUT*WOUT+1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]   ch_q;
  logic [PIX_W-1:0]  pix_q;
  logic [SEL_W-1:0]  sel_q;
  logic [IFM_AW-1:0] ifm_q;
  logic [OFM_AW-1:0] wr_q;

  logic go, run_last, wr_acc, sel_last, pix_last, timeout;

  assign go       = (state_q == S_IDLE) && start_i;
  assign run_last = (state_q == S_RUN) && (ch_q == CH_W'(CHIN));
  assign wr_acc   = (state_q == S_DRAIN) && wr_ready_i;
  assign sel_last = (sel_q == SEL_W'(DSP_NO-1));
  assign pix_last = (pix_q == PIX_W'(WOUT*WOUT-1));

`ifdef FIRE_SEQ_SAMPLE_TIMEOUT_EN
  localparam int TO   = SAMPLE_LAT + 8;
  localparam int WT_W = $clog2(TO+1);

  logic [WT_W-1:0] wait_q;
  logic            err_q;

  assign timeout = (state_q == S_WAIT) && !sample_i &&
                   (wait_q == WT_W'(TO-1));
  assign err_o   = err_q;

  // WAIT-cycle counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_WAIT) wait_q <= wait_q + WT_W'(1);
      else                   wait_q <= '0;
      if (go)           err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (run_last) state_d = S_WAIT;
      S_WAIT: begin
        if (sample_i)     state_d = S_DRAIN;
        else if (timeout) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (wr_acc && sel_last)
          state_d = pix_last ? S_DONE : S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // channel / pixel / select counters and address generators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      pix_q <= '0;
      sel_q <= '0;
      ifm_q <= '0;
      wr_q  <= '0;
    end else if (go) begin
      ch_q  <= '0;
      pix_q <= '0;
      sel_q <= '0;
      ifm_q <= '0;
      wr_q  <= '0;
    end else if (state_q == S_RUN) begin
      ch_q <= run_last ? '0 : ch_q + CH_W'(1);
      if (ch_q < CH_W'(CHIN-1)) ifm_q <= ifm_q + IFM_AW'(1);
    end else if (wr_acc) begin
      sel_q <= sel_last ? '0 : sel_q + SEL_W'(1);
      if (!(sel_last && pix_last)) wr_q <= wr_q + OFM_AW'(1);
      if (sel_last && !pix_last) begin
        pix_q <= pix_q + PIX_W'(1);
        ifm_q <= ifm_q + IFM_AW'(1);
      end
    end
  end

  assign layer_en_o = (state_q == S_RUN);
  assign ifm_rd_o   = (state_q == S_RUN) && (ch_q != CH_W'(CHIN));
  assign ifm_addr_o = ifm_q;
  assign wr_en_o    = wr_acc;
  assign wr_sel_o   = sel_q;
  assign wr_addr_o  = wr_q;
  assign busy_o     = (state_q == S_RUN) || (state_q == S_WAIT) ||
                      (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_fire_expand_seq.sv
// tb_fire_expand_seq: randomized self-checking bench for fire_expand_seq.
// Expected streams derive from layer geometry (WOUT=2, CHIN=4, DSP_NO=4).
module tb_fire_expand_seq;

  localparam int WOUT   = 2;
  localparam int CHIN   = 4;
  localparam int DSP_NO = 4;
  localparam int SLAT   = 4;
  localparam int NPIX   = WOUT*WOUT;
  localparam int IFM_AW = $clog2(NPIX*CHIN);
  localparam int OFM_AW = $clog2(NPIX*DSP_NO);
  localparam int SEL_W  = $clog2(DSP_NO);

  logic clk, rst, start_i, sample_i, wr_ready_i;
  logic layer_en_o, ifm_rd_o, wr_en_o, busy_o, done_o;
  logic [IFM_AW-1:0] ifm_addr_o;
  logic [SEL_W-1:0]  wr_sel_o;
  logic [OFM_AW-1:0] wr_addr_o;
`ifdef FIRE_SEQ_SAMPLE_TIMEOUT_EN
  logic err_o;
`endif

  int checks = 0;
  int failures = 0;

  fire_expand_seq #(
    .WOUT(WOUT), .CHIN(CHIN), .DSP_NO(DSP_NO), .SAMPLE_LAT(SLAT)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .layer_en_o(layer_en_o), .ifm_rd_o(ifm_rd_o),
    .ifm_addr_o(ifm_addr_o), .sample_i(sample_i),
    .wr_ready_i(wr_ready_i), .wr_en_o(wr_en_o),
    .wr_sel_o(wr_sel_o), .wr_addr_o(wr_addr_o),
`ifdef FIRE_SEQ_SAMPLE_TIMEOUT_EN
    .err_o(err_o),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; sample_i = 0; wr_ready_i = 0;
    repeat (3) tick();
    checks++;
    if ({layer_en_o, ifm_rd_o, ifm_addr_o, wr_en_o, wr_sel_o,
         wr_addr_o, busy_o, done_o} !== '0)
      begin
        failures++;
        $display("FAIL reset_outputs en=%b rd=%b ia=%0d we=%b sel=%0d wa=%0d busy=%b done=%b want all 0",
          layer_en_o, ifm_rd_o, ifm_addr_o, wr_en_o, wr_sel_o,
          wr_addr_o, busy_o, done_o);
      end
    rst = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || layer_en_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b en=%b want 0 0",
        busy_o, layer_en_o);
    end
  endtask

  // one full layer against the reference streams
  task automatic run_layer(input int ready_pct, input bit noise,
                           input int stall_addr, input int stall_len);
    int rd_exp, wr_exp, en_len, rd_pix, pix_wr, pix_done;
    int wait_left, stall_left, cyc;
    bit prev_en, in_wait, drain, drain_nxt, exp_done, exp_run, fin;
    rd_exp = 0; wr_exp = 0; en_len = 0; rd_pix = 0;
    pix_wr = 0; pix_done = 0; wait_left = 0; cyc = 0;
    stall_left = stall_len;
    prev_en = 0; in_wait = 0; drain = 0; drain_nxt = 0;
    exp_done = 0; exp_run = 0; fin = 0;
    start_i = 1; sample_i = 0; wr_ready_i = 0;
    while (!fin) begin
      tick();
      cyc++;
      if (cyc > 2000) begin
        checks++; failures++;
        $display("FAIL layer_timeout cycles=%0d writes=%0d want %0d",
          cyc, wr_exp, NPIX*DSP_NO);
        break;
      end
      if (exp_done) begin
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
          failures++;
          $display("FAIL done_pulse done=%b busy=%b want 1 0",
            done_o, busy_o);
        end
        fin = 1;
      end else begin
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
          failures++;
          $display("FAIL busy_level cyc=%0d done=%b busy=%b want 0 1",
            cyc, done_o, busy_o);
        end
      end
      if (cyc == 1 || exp_run) begin
        checks++;
        if (layer_en_o !== 1'b1) begin
          failures++;
          $display("FAIL run_start cyc=%0d en=%b want 1",
            cyc, layer_en_o);
        end
        exp_run = 0;
      end
      if (layer_en_o === 1'b1) begin
        en_len++;
        if (ifm_rd_o === 1'b1) begin
          checks++;
          if (ifm_addr_o !== rd_exp[IFM_AW-1:0] || rd_exp >= NPIX*CHIN) begin
            failures++;
            $display("FAIL ifm_addr got=%0d want=%0d", ifm_addr_o, rd_exp);
          end
          rd_exp++; rd_pix++;
        end else begin
          checks++;
          if (rd_pix != CHIN || en_len != CHIN+1 ||
              ifm_addr_o !== IFM_AW'(rd_exp-1)) begin
            failures++;
            $display("FAIL clear_slot reads=%0d pos=%0d addr=%0d want %0d %0d %0d",
              rd_pix, en_len, ifm_addr_o, CHIN, CHIN+1, rd_exp-1);
          end
        end
      end else if (prev_en) begin
        checks++;
        if (en_len != CHIN+1) begin
          failures++;
          $display("FAIL run_len got=%0d want=%0d", en_len, CHIN+1);
        end
        en_len = 0; rd_pix = 0; in_wait = 1;
        wait_left = $urandom_range(0, 5);
      end
      prev_en = layer_en_o;
      drain = drain_nxt;
      start_i = noise && (busy_o || done_o) &&
                ((exp_done) || ($urandom_range(0, 7) == 0));
      if (in_wait) begin
        if (wait_left == 0) begin
          sample_i = 1; in_wait = 0; drain_nxt = 1;
        end else begin
          sample_i = 0; wait_left--;
        end
      end else begin
        sample_i = noise && ($urandom_range(0, 3) == 0);
      end
      if (drain && stall_left > 0 && wr_exp == stall_addr) begin
        wr_ready_i = 0; stall_left--;
      end else begin
        wr_ready_i = int'($urandom_range(0, 99)) < ready_pct;
      end
      #1;
      checks++;
      if (wr_en_o !== (drain && wr_ready_i)) begin
        failures++;
        $display("FAIL wr_en cyc=%0d got=%b want=%b",
          cyc, wr_en_o, drain && wr_ready_i);
      end
      if (drain) begin
        checks++;
        if (wr_addr_o !== wr_exp[OFM_AW-1:0] ||
            wr_sel_o !== SEL_W'(wr_exp % DSP_NO)) begin
          failures++;
          $display("FAIL wr_addr got=%0d sel=%0d want=%0d sel=%0d",
            wr_addr_o, wr_sel_o, wr_exp, wr_exp % DSP_NO);
        end
        if (wr_ready_i) begin
          wr_exp++; pix_wr++;
          if (pix_wr == DSP_NO) begin
            pix_wr = 0; drain_nxt = 0; pix_done++;
            if (pix_done == NPIX) exp_done = 1;
            else exp_run = 1;
          end
        end
      end
    end
    checks++;
    if (rd_exp != NPIX*CHIN || wr_exp != NPIX*DSP_NO) begin
      failures++;
      $display("FAIL totals reads=%0d writes=%0d want %0d %0d",
        rd_exp, wr_exp, NPIX*CHIN, NPIX*DSP_NO);
    end
    tick();
    start_i = 0; sample_i = 0; wr_ready_i = 0;
    checks++;
    if (busy_o !== 1'b0 || layer_en_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done busy=%b en=%b done=%b want 0 0 0",
        busy_o, layer_en_o, done_o);
    end
    tick();
  endtask

  task automatic test_full_layer();
    run_layer(100, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_layer(100, 0, 6, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_layer(60, 1, -1, 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    start_i = 1; sample_i = 1; wr_ready_i = 1;
    tick();
    start_i = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (wr_en_o === 1'b1) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reach_drain got=0 want=1");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({layer_en_o, ifm_rd_o, ifm_addr_o, wr_en_o, wr_sel_o,
         wr_addr_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("FAIL async_reset en=%b we=%b wa=%0d busy=%b want all 0",
        layer_en_o, wr_en_o, wr_addr_o, busy_o);
    end
    sample_i = 0; wr_ready_i = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL no_done_after_abort done=%b busy=%b want 0 0",
          done_o, busy_o);
      end
    end
    run_layer(100, 0, -1, 0);
  endtask

`ifdef FIRE_SEQ_SAMPLE_TIMEOUT_EN
  task automatic test_timeout();
    start_i = 1; sample_i = 0; wr_ready_i = 1;
    tick();
    start_i = 0;
    for (int i = 0; i < CHIN + SLAT + 8; i++) begin
      tick();
      checks++;
      if (busy_o !== 1'b1 || err_o !== 1'b0) begin
        failures++;
        $display("FAIL wait_busy i=%0d busy=%b err=%b want 1 0",
          i, busy_o, err_o);
      end
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err busy=%b err=%b done=%b want 0 1 0",
        busy_o, err_o, done_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b want=1", err_o);
    end
    run_layer(100, 0, -1, 0);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b want=0", err_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_layer();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef FIRE_SEQ_SAMPLE_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
